// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: IF/DEC/EXEC/MEM/WB with a memory-ack timeout.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes in HALT.
module multicycle_control #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ack,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        MEM_Req,
  output logic        MEM_WrEn,
  output logic        ByteOp,
  output logic        Mem_Err,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    S_IF, S_DEC, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t state, nxt;
  logic [7:0] cnt;
  logic [5:0] op;

  logic is_r, is_imm, is_andi, is_ori;
  logic is_b, is_beq, is_bne;
  logic is_ld, is_st, is_byte;
  logic is_br, legal, take;

  logic ir, pc, ps, rw, wd, mr, mw, bo, err_set;

  logic unused_bits;
  assign unused_bits = ^Instr[25:4];

  assign op = Instr[31:26];

  always_comb begin
    is_r    = 1'b0;
    is_imm  = 1'b0;
    is_andi = 1'b0;
    is_ori  = 1'b0;
    is_b    = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_byte = 1'b0;
    case (op)
      6'b100000: is_r = 1'b1;
      6'b111000: is_imm = 1'b1;
      6'b111001: is_imm = 1'b1;
      6'b110000: is_imm = 1'b1;
      6'b110010: begin
        is_imm  = 1'b1;
        is_andi = 1'b1;
      end
      6'b110011: begin
        is_imm = 1'b1;
        is_ori = 1'b1;
      end
      6'b111111: is_b = 1'b1;
      6'b000000: is_beq = 1'b1;
      6'b000001: is_bne = 1'b1;
      6'b000011: begin
        is_ld   = 1'b1;
        is_byte = 1'b1;
      end
      6'b001111: is_ld = 1'b1;
      6'b000111: begin
        is_st   = 1'b1;
        is_byte = 1'b1;
      end
      6'b011111: is_st = 1'b1;
      default: ;
    endcase
  end

  assign is_br = is_b | is_beq | is_bne;
  assign legal = is_r | is_imm | is_br | is_ld | is_st;
  assign take  = is_b | (is_beq & Zero) | (is_bne & ~Zero);

  assign RF_B_sel    = is_st | is_beq | is_bne;
  assign ALU_Bin_sel = is_imm | is_ld | is_st;

  always_comb begin
    ALU_func = 4'b0000;
    unique case (1'b1)
      is_r:            ALU_func = Instr[3:0];
      is_andi:         ALU_func = 4'b0010;
      is_ori:          ALU_func = 4'b0011;
      is_beq | is_bne: ALU_func = 4'b0001;
      default:         ALU_func = 4'b0000;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IF;
      cnt     <= 8'd0;
      Mem_Err <= 1'b0;
    end else begin
      state   <= nxt;
      Mem_Err <= err_set;
      if (state != S_MEM)
        cnt <= 8'd0;
      else if (!Mem_Ack)
        cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    nxt     = state;
    ir      = 1'b0;
    pc      = 1'b0;
    ps      = 1'b0;
    rw      = 1'b0;
    wd      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    bo      = 1'b0;
    err_set = 1'b0;
    case (state)
      S_IF: begin
        ir  = 1'b1;
        nxt = S_DEC;
      end
      S_DEC: begin
        nxt = S_EXEC;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        if (!legal)
          nxt = S_HALT;
`endif
      end
      S_EXEC: begin
        if (is_br) begin
          pc  = 1'b1;
          ps  = take;
          nxt = S_IF;
        end else if (is_ld | is_st) begin
          nxt = S_MEM;
        end else if (legal) begin
          nxt = S_WB;
        end else begin
          // illegal opcode falls through as a NOP
          pc  = 1'b1;
          nxt = S_IF;
        end
      end
      S_MEM: begin
        mr = 1'b1;
        mw = is_st;
        bo = is_byte;
        if (Mem_Ack) begin
          if (is_st) begin
            pc  = 1'b1;
            nxt = S_IF;
          end else begin
            nxt = S_WB;
          end
        end else if (cnt == TLIM) begin
          pc      = 1'b1;
          err_set = 1'b1;
          nxt     = S_IF;
        end
      end
      S_WB: begin
        rw  = 1'b1;
        wd  = is_ld;
        pc  = 1'b1;
        nxt = S_IF;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  // reset gates enables combinationally so they drop without a clock
  assign IR_LdEn       = ir & Reset_n;
  assign PC_LdEn       = pc & Reset_n;
  assign PC_sel        = ps;
  assign RF_WrEn       = rw & Reset_n;
  assign RF_WrData_sel = wd;
  assign MEM_Req       = mr & Reset_n;
  assign MEM_WrEn      = mw & Reset_n;
  assign ByteOp        = bo;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign Illegal = (state == S_HALT);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output
// vectors are queued by the stimulus and checked by a negedge monitor.
module tb_multicycle_control;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Instr;
  logic        Zero;
  logic        Mem_Ack;
  logic        IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel;
  logic        RF_B_sel, ALU_Bin_sel, MEM_Req, MEM_WrEn, ByteOp;
  logic        Mem_Err, Illegal;
  logic [3:0]  ALU_func;

  multicycle_control #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Zero(Zero),
    .Mem_Ack(Mem_Ack), .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn),
    .PC_sel(PC_sel), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .MEM_Req(MEM_Req), .MEM_WrEn(MEM_WrEn),
    .ByteOp(ByteOp), .Mem_Err(Mem_Err), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  localparam logic [15:0] B_IR = 16'h8000;
  localparam logic [15:0] B_PC = 16'h4000;
  localparam logic [15:0] B_PS = 16'h2000;
  localparam logic [15:0] B_RW = 16'h1000;
  localparam logic [15:0] B_WD = 16'h0800;
  localparam logic [15:0] B_RB = 16'h0400;
  localparam logic [15:0] B_AB = 16'h0200;
  localparam logic [15:0] M_FN = 16'h01E0;
  localparam logic [15:0] B_MR = 16'h0010;
  localparam logic [15:0] B_MW = 16'h0008;
  localparam logic [15:0] B_BO = 16'h0004;
  localparam logic [15:0] B_ME = 16'h0002;
  localparam logic [15:0] B_IL = 16'h0001;
  localparam logic [15:0] EN =
    B_IR | B_PC | B_RW | B_MR | B_MW | B_ME | B_IL;

  typedef struct {
    string       nm;
    logic [15:0] v;
    logic [15:0] m;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   pend_err = 0;

  logic [15:0] outv;
  assign outv = {IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel,
                 RF_B_sel, ALU_Bin_sel, ALU_func, MEM_Req, MEM_WrEn,
                 ByteOp, Mem_Err, Illegal};

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if ((outv & e.m) !== (e.v & e.m)) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (mask %h)",
                 e.nm, outv & e.m, e.v & e.m, e.m);
      end
      n_chk++;
      if (RF_WrEn && MEM_WrEn) begin
        n_fail++;
        $display("FAIL %s_wr_excl: got RF_WrEn=1 MEM_WrEn=1 expected not both",
                 e.nm);
      end
    end
  end

  function automatic logic [15:0] fn(input logic [3:0] f);
    return {7'b0, f, 5'b0};
  endfunction

  task automatic cyc(input string nm, input logic [15:0] v,
                     input logic [15:0] m);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    e.m  = m | EN;
    q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input string nm, input logic [31:0] ins);
    Instr = ins;
    cyc({nm, ".if"}, B_IR | (pend_err ? B_ME : 16'h0), 16'h0);
    pend_err = 0;
  endtask

  task automatic run_alu(input string nm, input logic [31:0] ins,
                         input logic [3:0] f, input logic ab);
    fetch(nm, ins);
    cyc({nm, ".dec"}, 16'h0, B_RB);
    cyc({nm, ".exec"}, fn(f) | (ab ? B_AB : 16'h0), M_FN | B_AB);
    cyc({nm, ".wb"}, B_RW | B_PC, B_PS | B_WD);
  endtask

  task automatic run_br(input string nm, input logic [31:0] ins,
                        input logic z, input logic tk, input logic rb,
                        input logic [3:0] f);
    fetch(nm, ins);
    cyc({nm, ".dec"}, rb ? B_RB : 16'h0, B_RB);
    Zero = z;
    cyc({nm, ".exec"}, B_PC | (tk ? B_PS : 16'h0) | fn(f),
        B_PS | M_FN | B_AB);
    Zero = 1'b0;
  endtask

  // ack_at: MEM cycle (1-based) carrying Mem_Ack, 0 = never
  task automatic run_mem(input string nm, input logic [31:0] ins,
                         input logic st, input logic byt, input logic rb,
                         input int ack_at, input logic pre);
    int n;
    logic [15:0] row;
    Mem_Ack = pre;
    fetch(nm, ins);
    cyc({nm, ".dec"}, rb ? B_RB : 16'h0, B_RB);
    cyc({nm, ".exec"}, B_AB, M_FN | B_AB);
    n = (ack_at == 0) ? TO : ack_at;
    for (int i = 1; i <= n; i++) begin
      Mem_Ack = (i == ack_at);
      row = B_MR | (st ? B_MW : 16'h0) | (byt ? B_BO : 16'h0);
      if (i == n && (st || ack_at == 0))
        row = row | B_PC;
      cyc($sformatf("%s.mem%0d", nm, i), row, B_PS | B_BO);
    end
    Mem_Ack = 1'b0;
    if (ack_at == 0)
      pend_err = 1;
    else if (!st)
      cyc({nm, ".wb"}, B_RW | B_WD | B_PC, B_PS | B_WD);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    Instr   = 32'h0;
    Zero    = 1'b0;
    Mem_Ack = 1'b0;
    @(posedge Clk);
    #1;
    cyc("reset", 16'h0, 16'h0);
    cyc("reset2", 16'h0, 16'h0);
    Reset_n = 1'b1;

    run_alu("r", {6'b100000, 22'd0, 4'b0011}, 4'h3, 1'b0);
    run_alu("ori", {6'b110011, 26'h155}, 4'h3, 1'b1);
    run_alu("andi", {6'b110010, 26'h0a7}, 4'h2, 1'b1);
    run_alu("addi", {6'b110000, 26'h00f}, 4'h0, 1'b1);
    run_alu("li", {6'b111000, 26'h003}, 4'h0, 1'b1);

    run_br("beq_t", {6'b000000, 26'd0}, 1'b1, 1'b1, 1'b1, 4'h1);
    run_br("beq_n", {6'b000000, 26'd0}, 1'b0, 1'b0, 1'b1, 4'h1);
    run_br("bne_t", {6'b000001, 26'd0}, 1'b0, 1'b1, 1'b1, 4'h1);
    run_br("bne_n", {6'b000001, 26'd0}, 1'b1, 1'b0, 1'b1, 4'h1);
    run_br("b", {6'b111111, 26'd0}, 1'b0, 1'b1, 1'b0, 4'h0);

    run_mem("lw3", {6'b001111, 26'd0}, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_mem("lw1", {6'b001111, 26'd0}, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    run_mem("sw1", {6'b011111, 26'd0}, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    run_mem("sb_to", {6'b000111, 26'd0}, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    run_mem("sb_co", {6'b000111, 26'd0}, 1'b1, 1'b1, 1'b1, TO, 1'b0);
    run_mem("lb_pre", {6'b000011, 26'd0}, 1'b0, 1'b1, 1'b0, 2, 1'b1);

    fetch("ill", {6'b101010, 26'd0});
    cyc("ill.dec", 16'h0, B_RB);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      Mem_Ack = i[0];
      cyc($sformatf("ill.halt%0d", i), B_IL, 16'h0);
    end
    Mem_Ack = 1'b0;
    Reset_n = 1'b0;
    cyc("ill.rst", 16'h0, 16'h0);
    Reset_n = 1'b1;
`else
    cyc("ill.exec", B_PC, B_PS);
`endif
    run_alu("post_ill", {6'b100000, 22'd0, 4'b0101}, 4'h5, 1'b0);

    fetch("sw_rst", {6'b011111, 26'd0});
    cyc("sw_rst.dec", B_RB, B_RB);
    cyc("sw_rst.exec", B_AB, B_AB);
    cyc("sw_rst.mem1", B_MR | B_MW, 16'h0);
    #2;
    Reset_n = 1'b0;
    cyc("sw_rst.async", 16'h0, 16'h0);
    cyc("sw_rst.hold", 16'h0, 16'h0);
    Reset_n = 1'b1;
    run_alu("after_rst", {6'b100000, 22'd0, 4'b0011}, 4'h3, 1'b0);

    @(posedge Clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
